// File: rtl/smpl_trigger_sched.sv
// -----------------------------------------------------------------------------
// smpl_trigger_sched
// Sample-stream scheduler in the clkSmpl domain. It grants the ADC sample stream
// to one of NREQ display renderers per capture, chosen round-robin. It decimates
// the stream and waits for a level trigger, or for an auto timeout. It then
// forwards the decimated samples to the owner until the owner drops its request.
//
// Ports
//   clkSmpl      in   1     sample clock
//   n_reset      in   1     asynchronous, active-low reset
//   adc_valid    in   1     adc_data valid this cycle
//   adc_data     in   SN    raw sample
//   trig_level   in   SN    trigger threshold (unsigned)
//   trig_rising  in   1     1: rising-edge trigger, 0: falling-edge trigger
//   trig_auto    in   1     1: force a trigger after TOW-bit timeout
//   decim        in   DECW  keep 1 of (decim+1) valid samples
//   smpl_req     in   NREQ  per-requester request level
//   smpl_valid   out  NREQ  per-requester sample strobe
//   smpl         out  SN    shared sample bus (holds between strobes)
//   grant        out  NREQ  one-hot current owner (0 while idle)
//   triggered    out  1     high while streaming
//   auto_fired   out  1     1-cycle pulse when the trigger was forced
// -----------------------------------------------------------------------------
module smpl_trigger_sched #(
  parameter int SN   = 10,
  parameter int NREQ = 2,
  parameter int DECW = 8,
  parameter int TOW  = 12
) (
  input  logic            clkSmpl,
  input  logic            n_reset,
  input  logic            adc_valid,
  input  logic [SN-1:0]   adc_data,
  input  logic [SN-1:0]   trig_level,
  input  logic            trig_rising,
  input  logic            trig_auto,
  input  logic [DECW-1:0] decim,
  input  logic [NREQ-1:0] smpl_req,
  output logic [NREQ-1:0] smpl_valid,
  output logic [SN-1:0]   smpl,
  output logic [NREQ-1:0] grant,
  output logic            triggered,
  output logic            auto_fired
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TOW-1:0] TMAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, STREAM} state_t;

  state_t          state, state_nxt;

  logic [NREQ-1:0] grant_q;
  logic [OW-1:0]   owner_idx;
  logic [OW-1:0]   last_owner;
  logic [DECW-1:0] decim_q;
  logic [SN-1:0]   level_q;
  logic            rising_q;
  logic            auto_q;
  logic [DECW-1:0] dcnt;
  logic [TOW-1:0]  tcnt;
  logic [SN-1:0]   prev;
  logic            have_prev;
  logic [SN-1:0]   smpl_q;
  logic [NREQ-1:0] valid_q;
  logic            fired_q;

  logic            active;
  logic            kept;
  logic            release_req;
  logic            hit;
  logic            forced;
  logic            take;
  logic            start_stream;
  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  logic [OW-1:0]   scan;

  // Per-cycle qualifiers. A release takes priority over a kept sample in the same cycle.
  always_comb begin
    active       = (state != IDLE);
    kept         = active && adc_valid && (dcnt == decim_q);
    release_req  = active && ((smpl_req & grant_q) == '0);
    if (rising_q)
      hit = have_prev && (prev < level_q) && (adc_data >= level_q);
    else
      hit = have_prev && (prev > level_q) && (adc_data <= level_q);
    forced       = auto_q && (tcnt == TMAX) && !hit;
    take         = kept && !release_req;
    start_stream = (state == ARM) && take && (hit || forced);
  end

  // Round-robin pick: the first requester found searching upward from last_owner + 1 (mod NREQ).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_owner;
    scan       = last_owner;
    for (int i = 0; i < NREQ; i++) begin
      scan = (scan == OW'(NREQ - 1)) ? '0 : scan + OW'(1);
      if (!pick_found && smpl_req[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
    end
  end

  // State register
  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|smpl_req) state_nxt = ARM;
      ARM: begin
        if (release_req)       state_nxt = IDLE;
        else if (start_stream) state_nxt = STREAM;
      end
      STREAM:  if (release_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    triggered  = (state == STREAM);
    smpl_valid = valid_q;
    smpl       = smpl_q;
    grant      = grant_q;
    auto_fired = fired_q;
  end

  // Capture datapath: grant/config latch, decimation, trigger history and the sample strobe.
  always_ff @(posedge clkSmpl or negedge n_reset) begin
    if (!n_reset) begin
      grant_q    <= '0;
      owner_idx  <= '0;
      last_owner <= OW'(NREQ - 1);
      decim_q    <= '0;
      level_q    <= '0;
      rising_q   <= 1'b0;
      auto_q     <= 1'b0;
      dcnt       <= '0;
      tcnt       <= '0;
      prev       <= '0;
      have_prev  <= 1'b0;
      smpl_q     <= '0;
      valid_q    <= '0;
      fired_q    <= 1'b0;
    end else begin
      valid_q <= '0;
      fired_q <= 1'b0;
      if (state == IDLE) begin
        if (|smpl_req) begin
          grant_q   <= NREQ'(1) << pick_idx;
          owner_idx <= pick_idx;
          decim_q   <= decim;
          level_q   <= trig_level;
          rising_q  <= trig_rising;
          auto_q    <= trig_auto;
          dcnt      <= '0;
          tcnt      <= '0;
          have_prev <= 1'b0;
        end
      end else if (release_req) begin
        grant_q    <= '0;
        last_owner <= owner_idx;
      end else begin
        if (adc_valid)
          dcnt <= (dcnt == decim_q) ? '0 : dcnt + DECW'(1);
        if (take) begin
          if (state == ARM) begin
            prev      <= adc_data;
            have_prev <= 1'b1;
            if (tcnt != TMAX)
              tcnt <= tcnt + TOW'(1);
            if (forced)
              fired_q <= 1'b1;
          end
          if ((state == STREAM) || hit || forced) begin
            smpl_q  <= adc_data;
            valid_q <= grant_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_smpl_trigger_sched.sv
// -----------------------------------------------------------------------------
// tb_smpl_trigger_sched
// Directed testbench for smpl_trigger_sched (TOW = 4 so the auto timeout is
// short). A table of vectors covers plain and decimated triggering. Hand-written
// sequences cover auto trigger, round-robin, abort in Arm and async reset.
// -----------------------------------------------------------------------------
module tb_smpl_trigger_sched;

  localparam int SN   = 10;
  localparam int NREQ = 2;
  localparam int DECW = 8;
  localparam int TOW  = 4;

  logic            clkSmpl = 1'b0;
  logic            n_reset;
  logic            adc_valid;
  logic [SN-1:0]   adc_data;
  logic [SN-1:0]   trig_level;
  logic            trig_rising;
  logic            trig_auto;
  logic [DECW-1:0] decim;
  logic [NREQ-1:0] smpl_req;
  logic [NREQ-1:0] smpl_valid;
  logic [SN-1:0]   smpl;
  logic [NREQ-1:0] grant;
  logic            triggered;
  logic            auto_fired;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic            av;
    logic [SN-1:0]   ad;
    logic [NREQ-1:0] req;
    logic [DECW-1:0] dec;
    logic [SN-1:0]   lvl;
    logic            rise;
    logic            aut;
    logic [NREQ-1:0] e_valid;
    logic [SN-1:0]   e_smpl;
    logic [NREQ-1:0] e_grant;
    logic            e_trig;
    logic            e_auto;
  } vec_t;

  vec_t vecs[$];

  smpl_trigger_sched #(.SN(SN), .NREQ(NREQ), .DECW(DECW), .TOW(TOW)) dut (
    .clkSmpl    (clkSmpl),
    .n_reset    (n_reset),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (trig_level),
    .trig_rising(trig_rising),
    .trig_auto  (trig_auto),
    .decim      (decim),
    .smpl_req   (smpl_req),
    .smpl_valid (smpl_valid),
    .smpl       (smpl),
    .grant      (grant),
    .triggered  (triggered),
    .auto_fired (auto_fired)
  );

  always #5 clkSmpl = ~clkSmpl;

  task automatic addVec(input logic av, input int ad, input logic [1:0] req,
                        input int dec, input int lvl, input logic rise, input logic aut,
                        input logic [1:0] ev, input int es, input logic [1:0] eg,
                        input logic et, input logic ea);
    vec_t v;
    v.av = av; v.ad = SN'(ad); v.req = req; v.dec = DECW'(dec); v.lvl = SN'(lvl);
    v.rise = rise; v.aut = aut; v.e_valid = ev; v.e_smpl = SN'(es); v.e_grant = eg;
    v.e_trig = et; v.e_auto = ea;
    vecs.push_back(v);
  endtask

  task automatic setConfig(input int dec, input int lvl, input logic rise, input logic aut);
    decim       = DECW'(dec);
    trig_level  = SN'(lvl);
    trig_rising = rise;
    trig_auto   = aut;
  endtask

  // Drives one cycle of inputs and returns 1 time unit after the active edge.
  task automatic applyStimulus(input logic av, input int ad, input logic [1:0] req);
    adc_valid = av;
    adc_data  = SN'(ad);
    smpl_req  = req;
    @(posedge clkSmpl);
    #1;
  endtask

  task automatic checkField(input string name, input string field, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("[TB] FAIL %s %s: got %0d want %0d", name, field, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ev, input int es,
                             input logic [1:0] eg, input logic et, input logic ea);
    checkField(name, "smpl_valid", int'(smpl_valid), int'(ev));
    checkField(name, "smpl",       int'(smpl),       es);
    checkField(name, "grant",      int'(grant),      int'(eg));
    checkField(name, "triggered",  int'(triggered),  int'(et));
    checkField(name, "auto_fired", int'(auto_fired), int'(ea));
  endtask

  initial begin
    int cur;
    logic kept_s;

    // Table: plain rising trigger on a ramp, then a decim=3 capture
    addVec(0, 0, 2'b01, 0, 512, 1, 0, 2'b00, 0, 2'b01, 0, 0);
    for (int d = 500; d <= 520; d++)
      addVec(1, d, 2'b01, 0, 512, 1, 0, (d >= 512) ? 2'b01 : 2'b00,
             (d >= 512) ? d : 0, 2'b01, d >= 512, 0);
    addVec(1, 521, 2'b00, 0, 512, 1, 0, 2'b00, 520, 2'b00, 0, 0);
    addVec(0, 0,   2'b00, 0, 512, 1, 0, 2'b00, 520, 2'b00, 0, 0);
    addVec(0, 0,   2'b01, 3, 512, 1, 0, 2'b00, 520, 2'b01, 0, 0);
    cur = 520;
    for (int d = 501; d <= 524; d++) begin
      kept_s = ((d - 501) % 4) == 3;
      if (kept_s && d >= 512) cur = d;
      addVec(1, d, 2'b01, 3, 512, 1, 0, (kept_s && d >= 512) ? 2'b01 : 2'b00,
             cur, 2'b01, d >= 512, 0);
    end
    addVec(0, 0, 2'b00, 3, 512, 1, 0, 2'b00, 524, 2'b00, 0, 0);
    addVec(0, 0, 2'b00, 3, 512, 1, 0, 2'b00, 524, 2'b00, 0, 0);

    adc_valid = 1'b0;
    adc_data  = '0;
    smpl_req  = '0;
    setConfig(0, 512, 1, 0);
    n_reset   = 1'b0;
    #12;
    checkOutput("reset", 2'b00, 0, 2'b00, 0, 0);
    n_reset = 1'b1;
    @(posedge clkSmpl);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      setConfig(int'(vecs[i].dec), int'(vecs[i].lvl), vecs[i].rise, vecs[i].aut);
      applyStimulus(vecs[i].av, int'(vecs[i].ad), vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, int'(vecs[i].e_smpl),
                  vecs[i].e_grant, vecs[i].e_trig, vecs[i].e_auto);
    end

    // Auto trigger: falling, level 100, constant 200 never hits; 16th kept sample forces
    setConfig(0, 100, 0, 1);
    applyStimulus(0, 0, 2'b01);
    checkOutput("auto_grant", 2'b00, 524, 2'b01, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(1, 200, 2'b01);
      checkOutput($sformatf("auto_wait%0d", k), 2'b00, 524, 2'b01, 0, 0);
    end
    applyStimulus(1, 200, 2'b01);
    checkOutput("auto_fire", 2'b01, 200, 2'b01, 1, 1);
    applyStimulus(1, 200, 2'b01);
    checkOutput("auto_after", 2'b01, 200, 2'b01, 1, 0);
    applyStimulus(0, 0, 2'b00);
    checkOutput("auto_release", 2'b00, 200, 2'b00, 0, 0);

    // Round-robin, starting from a fresh reset (last owner = 1)
    n_reset = 1'b0;
    #2;
    checkOutput("rr_reset", 2'b00, 0, 2'b00, 0, 0);
    n_reset = 1'b1;
    setConfig(0, 512, 1, 0);
    applyStimulus(0, 0, 2'b11);
    checkOutput("rr_grant0", 2'b00, 0, 2'b01, 0, 0);
    applyStimulus(1, 511, 2'b11);
    checkOutput("rr_arm", 2'b00, 0, 2'b01, 0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 512 + k, 2'b11);
      checkOutput($sformatf("rr_stream%0d", k), 2'b01, 512 + k, 2'b01, 1, 0);
    end
    applyStimulus(1, 520, 2'b10);
    checkOutput("rr_drop0", 2'b00, 519, 2'b00, 0, 0);
    applyStimulus(0, 0, 2'b11);
    checkOutput("rr_grant1", 2'b00, 519, 2'b10, 0, 0);
    applyStimulus(1, 511, 2'b11);
    applyStimulus(1, 512, 2'b11);
    checkOutput("rr_owner1_strobe", 2'b10, 512, 2'b10, 1, 0);
    applyStimulus(0, 0, 2'b01);
    checkOutput("rr_drop1", 2'b00, 512, 2'b00, 0, 0);
    applyStimulus(0, 0, 2'b11);
    checkOutput("rr_grant0_again", 2'b00, 512, 2'b01, 0, 0);

    // Abort in Arm: the release cycle carries a would-be hit
    applyStimulus(1, 511, 2'b01);
    checkOutput("abort_arm", 2'b00, 512, 2'b01, 0, 0);
    applyStimulus(1, 512, 2'b00);
    checkOutput("abort_release", 2'b00, 512, 2'b00, 0, 0);
    applyStimulus(0, 0, 2'b00);
    checkOutput("abort_idle", 2'b00, 512, 2'b00, 0, 0);

    // No trigger and no auto: Arm holds well past the timeout count
    applyStimulus(0, 0, 2'b01);
    checkOutput("hold_grant", 2'b00, 512, 2'b01, 0, 0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1, 100, 2'b01);
      if (k % 8 == 7)
        checkOutput($sformatf("hold%0d", k), 2'b00, 512, 2'b01, 0, 0);
    end

    // Async reset in the middle of a stream
    applyStimulus(1, 600, 2'b01);
    checkOutput("mid_trigger", 2'b01, 600, 2'b01, 1, 0);
    applyStimulus(1, 601, 2'b01);
    checkOutput("mid_stream", 2'b01, 601, 2'b01, 1, 0);
    #2;
    n_reset = 1'b0;
    #1;
    checkOutput("mid_reset", 2'b00, 0, 2'b00, 0, 0);
    #2;
    n_reset = 1'b1;
    applyStimulus(0, 0, 2'b11);
    checkOutput("post_reset_grant", 2'b00, 0, 2'b01, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
